// File: rtl/vga_pattern_gen_if.sv
// Video output bundle between the pattern generator and the board pins.
// Latency: none; these are plain wires.
// Backpressure: none; the pixel stream runs freely at one pixel per clock.
//
// master: driven by vga_pattern_gen. It reads mode and drives the sync, position,
//         colour, active_mode and frame_tick signals.
// slave : the consumer side. It drives mode and observes everything else.
interface vga_pattern_gen_if #(
   parameter int CNT_W    = 10,
   parameter int RGB_BITS = 1
);
   logic [1:0]          mode;
   logic                hsync;
   logic                vsync;
   logic                display_on;
   logic [CNT_W-1:0]    pos_x;
   logic [CNT_W-1:0]    pos_y;
   logic [RGB_BITS-1:0] red;
   logic [RGB_BITS-1:0] green;
   logic [RGB_BITS-1:0] blue;
   logic [1:0]          active_mode;
   logic                frame_tick;

   modport master (
      input  mode,
      output hsync, vsync, display_on, pos_x, pos_y,
      output red, green, blue, active_mode, frame_tick
   );

   modport slave (
      output mode,
      input  hsync, vsync, display_on, pos_x, pos_y,
      input  red, green, blue, active_mode, frame_tick
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA sync timing and selectable test-pattern generator (bars, checker, border, mode 3).
// Latency: every output is registered one clock after the counter state it describes.
// Backpressure: none; this is a free-running stream of one pixel per clock.
//
// Ports: clk (pixel clock), reset (synchronous, active-high), vid (vga_pattern_gen_if.master).
//   vid.mode is the requested pattern. It is latched into active_mode on the last clock of a frame.
//   vid.hsync/vsync/display_on/pos_x/pos_y/red/green/blue/frame_tick are aligned to the same pixel.
// Optional feature macro: PATTERN_ANIM_EN. When it is defined, mode 3 is a bouncing white box.
//   When it is undefined, mode 3 draws the colour bars.
module vga_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit SYNC_POL   = 1'b0,
   parameter int RGB_BITS   = 1,
   parameter int CNT_W      = 10,
   parameter int CHECK_LOG2 = 5,
   parameter int BOX        = 32
) (
   input  logic              clk,
   input  logic              reset,
   vga_pattern_gen_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_EDGE   = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_EDGE   = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] BAR_W    = CNT_W'(H_ACTIVE / 8);

   // Reject parameter sets that the counters or the pattern logic cannot represent.
   if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W)) || (BOX > H_ACTIVE) ||
       (BOX > V_ACTIVE) || ((H_ACTIVE % 8) != 0) || (CHECK_LOG2 >= CNT_W)) begin : g_bad_cfg
      $error("vga_pattern_gen: parameter set out of range");
   end

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             line_end;
   logic             frame_end;

   assign line_end  = (h_cnt == H_LAST);
   assign frame_end = line_end && (v_cnt == V_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (line_end) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
      end else begin
         h_cnt <= h_cnt + CNT_ONE;
      end
   end

`ifdef PATTERN_ANIM_EN
   // Bouncing box. The position moves once per frame, on the same clock that latches the mode,
   // so the box never tears mid-frame.
   localparam logic [CNT_W-1:0] BX_MAX  = CNT_W'(H_ACTIVE - BOX);
   localparam logic [CNT_W-1:0] BY_MAX  = CNT_W'(V_ACTIVE - BOX);
   localparam logic [CNT_W:0]   BOX_EXT = (CNT_W+1)'(BOX);

   logic [CNT_W-1:0] bx;
   logic [CNT_W-1:0] by;
   logic [CNT_W-1:0] bx_nxt;
   logic [CNT_W-1:0] by_nxt;
   logic             dx_neg;
   logic             dy_neg;
   logic             in_box;

   assign bx_nxt = dx_neg ? bx - CNT_ONE : bx + CNT_ONE;
   assign by_nxt = dy_neg ? by - CNT_ONE : by + CNT_ONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         bx     <= '0;
         by     <= '0;
         dx_neg <= 1'b0;
         dy_neg <= 1'b0;
      end else if (frame_end) begin
         bx <= bx_nxt;
         by <= by_nxt;
         if (bx_nxt == BX_MAX) begin
            dx_neg <= 1'b1;
         end else if (bx_nxt == '0) begin
            dx_neg <= 1'b0;
         end
         if (by_nxt == BY_MAX) begin
            dy_neg <= 1'b1;
         end else if (by_nxt == '0) begin
            dy_neg <= 1'b0;
         end
      end
   end

   // The upper bound is computed one bit wider so that bx+BOX cannot wrap.
   assign in_box = ({1'b0, h_cnt} >= {1'b0, bx}) && ({1'b0, h_cnt} < ({1'b0, bx} + BOX_EXT)) &&
                   ({1'b0, v_cnt} >= {1'b0, by}) && ({1'b0, v_cnt} < ({1'b0, by} + BOX_EXT));
`endif

   logic       visible;
   logic       hs_act;
   logic       vs_act;
   logic [2:0] idx_bars;
   logic [2:0] idx_checker;
   logic [2:0] idx_border;
   logic [2:0] idx_sel;

   // A colour index is {R,G,B}. Blanking is applied at the output register.
   always_comb begin
      visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_act      = (h_cnt >= HS_START) && (h_cnt < HS_END);
      vs_act      = (v_cnt >= VS_START) && (v_cnt < VS_END);
      idx_bars    = 3'(h_cnt / BAR_W);
      idx_checker = {3{h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]}};
      idx_border  = {3{(h_cnt == '0) || (h_cnt == H_EDGE) || (v_cnt == '0) || (v_cnt == V_EDGE)}};
      idx_sel     = idx_bars;
      case (vid.active_mode)
         2'd1:    idx_sel = idx_checker;
         2'd2:    idx_sel = idx_border;
`ifdef PATTERN_ANIM_EN
         2'd3:    idx_sel = {3{in_box}};
`endif
         default: idx_sel = idx_bars;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vid.hsync       <= ~SYNC_POL;
         vid.vsync       <= ~SYNC_POL;
         vid.display_on  <= 1'b0;
         vid.pos_x       <= '0;
         vid.pos_y       <= '0;
         vid.red         <= '0;
         vid.green       <= '0;
         vid.blue        <= '0;
         vid.active_mode <= 2'd0;
         vid.frame_tick  <= 1'b0;
      end else begin
         vid.hsync      <= hs_act ? SYNC_POL : ~SYNC_POL;
         vid.vsync      <= vs_act ? SYNC_POL : ~SYNC_POL;
         vid.display_on <= visible;
         vid.pos_x      <= h_cnt;
         vid.pos_y      <= v_cnt;
         vid.red        <= {RGB_BITS{idx_sel[2] & visible}};
         vid.green      <= {RGB_BITS{idx_sel[1] & visible}};
         vid.blue       <= {RGB_BITS{idx_sel[0] & visible}};
         vid.frame_tick <= (h_cnt == '0) && (v_cnt == '0);
         if (frame_end) begin
            vid.active_mode <= vid.mode;
         end
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
`timescale 1ns/1ps
module tb_vga_pattern_gen;
   // Reduced raster so that many frames fit in a short run.
   localparam int HA = 32, HFP = 2, HSW = 4, HBP = 2, HT = HA + HFP + HSW + HBP;  // 40
   localparam int VA = 24, VFP = 1, VSW = 2, VBP = 1, VT = VA + VFP + VSW + VBP;  // 28
   localparam int FT = HT * VT;                                                   // 1120
   localparam int CW = 10, RB = 2, CL = 2, BOXP = 8;
`ifdef PATTERN_ANIM_EN
   localparam int NF_ANIM = 26;
`else
   localparam int NF_ANIM = 3;
`endif

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          de;
      logic [CW-1:0] px;
      logic [CW-1:0] py;
      logic [RB-1:0] r;
      logic [RB-1:0] g;
      logic [RB-1:0] b;
      logic [1:0]    am;
      logic          tk;
   } pix_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #20 clk = ~clk;

   vga_pattern_gen_if #(.CNT_W(CW), .RGB_BITS(RB)) vid ();

   vga_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(1'b0), .RGB_BITS(RB), .CNT_W(CW), .CHECK_LOG2(CL), .BOX(BOXP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .vid   (vid)
   );

   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;       // index of the pixel that the next clock presents
   logic [1:0] m_mode = 2'd0;    // the pattern the model is currently drawing
   pix_t       sb[$];

   function automatic int tri_pos(int f, int lim);
      int p = f % (2 * lim);
      return (p <= lim) ? p : 2 * lim - p;
   endfunction

   function automatic pix_t model(int c, logic [1:0] draw_mode, logic [1:0] shown_mode);
      pix_t p;
      int h = c % HT;
      int v = (c / HT) % VT;
      int f = c / FT;
      bit vis = (h < HA) && (v < VA);
      logic [2:0] idx;
      case (draw_mode)
         2'd1: idx = ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? 3'd7 : 3'd0;
         2'd2: idx = (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) ? 3'd7 : 3'd0;
`ifdef PATTERN_ANIM_EN
         2'd3: begin
            int bx = tri_pos(f, HA - BOXP);
            int by = tri_pos(f, VA - BOXP);
            idx = (h >= bx && h < bx + BOXP && v >= by && v < by + BOXP) ? 3'd7 : 3'd0;
         end
`endif
         default: idx = 3'(h / (HA / 8));
      endcase
      p.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? 1'b0 : 1'b1;
      p.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? 1'b0 : 1'b1;
      p.de = vis;
      p.px = CW'(h);
      p.py = CW'(v);
      p.r  = (vis && idx[2]) ? '1 : '0;
      p.g  = (vis && idx[1]) ? '1 : '0;
      p.b  = (vis && idx[0]) ? '1 : '0;
      p.am = shown_mode;
      p.tk = (h == 0 && v == 0);
      return p;
   endfunction

   function automatic pix_t observe();
      pix_t p;
      p.hs = vid.hsync;       p.vs = vid.vsync;      p.de = vid.display_on;
      p.px = vid.pos_x;       p.py = vid.pos_y;
      p.r  = vid.red;         p.g  = vid.green;      p.b  = vid.blue;
      p.am = vid.active_mode; p.tk = vid.frame_tick;
      return p;
   endfunction

   // Pushes the expected value for the pixel that the next clock presents, then clocks once.
   // The mode input is latched on the last pixel of a frame, so the active_mode shown with that
   // pixel is already the new one while the colour still follows the old one.
   task automatic drive_cycle();
      logic [1:0] nm;
      nm = ((cyc % FT) == FT - 1) ? vid.mode : m_mode;
      sb.push_back(model(cyc, m_mode, nm));
      @(posedge clk);
      m_mode = nm;
      cyc++;
   endtask

   // Called at a negedge. The next posedge is the first clock after reset.
   task automatic release_reset();
      reset  = 1'b0;
      cyc    = 0;
      m_mode = 2'd0;
      sb.delete();
   endtask

   task automatic test_reset();
      pix_t got;
      vid.mode = 2'd2;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = observe();
      checks++; if (got.hs !== 1'b1) begin errors++; $display("FAIL rst_hsync got=%b exp=1", got.hs); end
      checks++; if (got.vs !== 1'b1) begin errors++; $display("FAIL rst_vsync got=%b exp=1", got.vs); end
      checks++; if (got.de !== 1'b0) begin errors++; $display("FAIL rst_display_on got=%b exp=0", got.de); end
      checks++; if ({got.r, got.g, got.b} !== '0) begin errors++; $display("FAIL rst_rgb got=%h exp=0", {got.r, got.g, got.b}); end
      checks++; if (got.tk !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", got.tk); end
      checks++; if ({got.px, got.py} !== '0) begin errors++; $display("FAIL rst_pos got=%0d,%0d exp=0,0", got.px, got.py); end
      checks++; if (got.am !== 2'd0) begin errors++; $display("FAIL rst_mode got=%0d exp=0", got.am); end
   endtask

   // Frame 0 shows the bars, plus sync, visible-area and tick counts over one whole frame.
   task automatic test_bars();
      pix_t got, exp;
      int n_hs = 0, n_vs = 0, n_de = 0, n_tk = 0;
      vid.mode = 2'd0;
      release_reset();
      for (int i = 0; i < FT; i++) begin
         drive_cycle();
         @(negedge clk);
         got = observe();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL bars_pixel cyc=%0d got=%h exp=%h", cyc - 1, got, exp); end
         if (got.hs === 1'b0) n_hs++;
         if (got.vs === 1'b0) n_vs++;
         if (got.de === 1'b1) n_de++;
         if (got.tk === 1'b1) n_tk++;
         if (cyc - 1 == 0) begin
            checks++;
            if (got.tk !== 1'b1 || got.px !== '0 || got.py !== '0)
               begin errors++; $display("FAIL first_pixel tick=%b pos=%0d,%0d exp tick=1 pos=0,0", got.tk, got.px, got.py); end
         end
         if (cyc - 1 == 4) begin
            checks++;
            if ({got.r, got.g, got.b} !== 6'b00_00_11) begin errors++; $display("FAIL bar1_blue got=%b exp=000011", {got.r, got.g, got.b}); end
         end
         if (cyc - 1 == HA - 1) begin
            checks++;
            if ({got.r, got.g, got.b} !== 6'b11_11_11) begin errors++; $display("FAIL bar7_white got=%b exp=111111", {got.r, got.g, got.b}); end
         end
         if (cyc - 1 >= HA && cyc - 1 < HT) begin
            checks++;
            if ({got.r, got.g, got.b} !== '0) begin errors++; $display("FAIL hblank_rgb x=%0d got=%b exp=0", cyc - 1, {got.r, got.g, got.b}); end
         end
      end
      checks++; if (n_hs != HSW * VT) begin errors++; $display("FAIL hsync_count got=%0d exp=%0d", n_hs, HSW * VT); end
      checks++; if (n_vs != VSW * HT) begin errors++; $display("FAIL vsync_count got=%0d exp=%0d", n_vs, VSW * HT); end
      checks++; if (n_de != HA * VA) begin errors++; $display("FAIL display_on_count got=%0d exp=%0d", n_de, HA * VA); end
      checks++; if (n_tk != 1) begin errors++; $display("FAIL tick_count got=%0d exp=1", n_tk); end
   endtask

   // Mode 1 is requested mid frame 1, so frame 1 keeps the bars and frame 2 shows the checker.
   // Mode 2 is requested mid frame 2 and must not disturb the checker.
   task automatic test_mode_change();
      pix_t got, exp;
      for (int i = 0; i < 2 * FT; i++) begin
         drive_cycle();
         @(negedge clk);
         got = observe();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL mode_change_pixel cyc=%0d got=%h exp=%h", cyc - 1, got, exp); end
         if (cyc - 1 == FT + 4) begin
            checks++;
            if ({got.r, got.g, got.b} !== 6'b00_00_11) begin errors++; $display("FAIL old_frame_bars got=%b exp=000011", {got.r, got.g, got.b}); end
         end
         if (cyc - 1 == 2 * FT) begin
            checks++;
            if (got.tk !== 1'b1 || got.am !== 2'd1 || {got.r, got.g, got.b} !== '0)
               begin errors++; $display("FAIL checker_origin tick=%b mode=%0d rgb=%b exp 1,1,0", got.tk, got.am, {got.r, got.g, got.b}); end
         end
         if (cyc - 1 == 2 * FT + 4) begin
            checks++;
            if ({got.r, got.g, got.b} !== '1) begin errors++; $display("FAIL checker_white got=%b exp=111111", {got.r, got.g, got.b}); end
         end
         if (i == 10 * HT) vid.mode = 2'd1;
         if (i == FT + 10 * HT) vid.mode = 2'd2;
      end
   endtask

   // Frame 3 is the border. Mode 3 is requested during it.
   task automatic test_border();
      pix_t got, exp;
      for (int i = 0; i < FT; i++) begin
         drive_cycle();
         @(negedge clk);
         got = observe();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL border_pixel cyc=%0d got=%h exp=%h", cyc - 1, got, exp); end
         if (i == HT + 1) begin
            checks++;
            if ({got.r, got.g, got.b} !== '0) begin errors++; $display("FAIL border_inner got=%b exp=0", {got.r, got.g, got.b}); end
         end
         if (i == HT + HA - 1) begin
            checks++;
            if ({got.r, got.g, got.b} !== '1 || got.am !== 2'd2)
               begin errors++; $display("FAIL border_right rgb=%b mode=%0d exp 111111,2", {got.r, got.g, got.b}, got.am); end
         end
         if (i == 5 * HT) vid.mode = 2'd3;
      end
   endtask

   // Frame 4 shows mode 3, then a one-clock reset is applied in the middle of frame 5.
   task automatic test_mode3_and_midframe_reset();
      pix_t got, exp;
      for (int i = 0; i < FT + 10 * HT + 15; i++) begin
         drive_cycle();
         @(negedge clk);
         got = observe();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL mode3_pixel cyc=%0d got=%h exp=%h", cyc - 1, got, exp); end
         if (i == 4 * HT + 4) begin
            checks++;
`ifdef PATTERN_ANIM_EN
            if ({got.r, got.g, got.b} !== '1 || got.am !== 2'd3)
`else
            if ({got.r, got.g, got.b} !== 6'b00_00_11 || got.am !== 2'd3)
`endif
               begin errors++; $display("FAIL mode3_spot rgb=%b mode=%0d", {got.r, got.g, got.b}, got.am); end
         end
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      got = observe();
      checks++;
      if (got.de !== 1'b0 || got.tk !== 1'b0 || got.hs !== 1'b1 || got.am !== 2'd0 || got.px !== '0)
         begin errors++; $display("FAIL midframe_reset_state got=%h", got); end
      release_reset();
      drive_cycle();
      @(negedge clk);
      got = observe();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL post_reset_pixel got=%h exp=%h", got, exp); end
      checks++;
      if (got.tk !== 1'b1 || got.px !== '0 || got.py !== '0 || got.am !== 2'd0)
         begin errors++; $display("FAIL post_reset_tick tick=%b pos=%0d,%0d mode=%0d exp 1,0,0,0", got.tk, got.px, got.py, got.am); end
   endtask

   // Mode 3 runs over many frames. With the box enabled, this covers the bounce at the right edge.
   task automatic test_back_to_back_frames();
      pix_t got, exp;
      while (cyc < NF_ANIM * FT) begin
         drive_cycle();
         @(negedge clk);
         got = observe();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL frames_pixel cyc=%0d got=%h exp=%h", cyc - 1, got, exp); end
`ifdef PATTERN_ANIM_EN
         if (cyc - 1 == 24 * FT + 8 * HT + 24) begin
            checks++;
            if ({got.r, got.g, got.b} !== '1) begin errors++; $display("FAIL box_at_max got=%b exp=111111", {got.r, got.g, got.b}); end
         end
         if (cyc - 1 == 25 * FT + 8 * HT + 23) begin
            checks++;
            if ({got.r, got.g, got.b} !== '1) begin errors++; $display("FAIL box_bounce got=%b exp=111111", {got.r, got.g, got.b}); end
         end
         if (cyc - 1 == 25 * FT + 8 * HT + 31) begin
            checks++;
            if ({got.r, got.g, got.b} !== '0) begin errors++; $display("FAIL box_right_edge got=%b exp=0", {got.r, got.g, got.b}); end
         end
`endif
      end
   endtask

   initial begin
      vid.mode = 2'd0;
      @(negedge clk);
      test_reset();
      test_bars();
      test_mode_change();
      test_border();
      test_mode3_and_midframe_reset();
      test_back_to_back_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
